// File: rtl/instr_decode_stage.sv
// RV32I/E instruction-decode pipeline stage: registered field split, immediate build,
// ALU control and illegal detection. Define FRISCV_ID_SKID_EN for a one-entry skid buffer.
module instr_decode_stage #(
  parameter int ARCH          = 32,
  parameter int REGFILE_DEPTH = 32,
  localparam int RW           = $clog2(REGFILE_DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr_in,
  input  logic [ARCH-1:0] pc_in,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic            flush_in,
  output logic            valid_out,
  input  logic            ready_in,
  output logic [ARCH-1:0] pc_out,
  output logic [6:0]      op_code_out,
  output logic [2:0]      func3_out,
  output logic [6:0]      func7_out,
  output logic [RW-1:0]   rs1_out,
  output logic [RW-1:0]   rs2_out,
  output logic [RW-1:0]   rd_out,
  output logic [ARCH-1:0] imm_out,
  output logic [2:0]      instr_type_out,
  output logic [3:0]      alu_ctrl_out,
  output logic            illegal_out
);

  localparam logic [6:0] OP_R = 7'b0110011, OP_IMM = 7'b0010011, OP_LOAD = 7'b0000011,
                         OP_JALR = 7'b1100111, OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011,
                         OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111;
  localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3, T_U = 3'd4,
                         T_J = 3'd5, T_ILL = 3'd7;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                         ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASS_B = 4'd10;

  typedef struct packed {
    logic [ARCH-1:0] pc;
    logic [6:0]      op_code;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [RW-1:0]   rd;
    logic [ARCH-1:0] imm;
    logic [2:0]      itype;
    logic [3:0]      alu;
    logic            illegal;
  } entry_t;

  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic f7b5,
                                             input logic is_r);
    case (f3)
      3'b000:  return (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic signed [11:0] imm_i_s, imm_s_s;
  logic signed [12:0] imm_b_s;
  logic signed [31:0] imm_u_s;
  logic signed [20:0] imm_j_s;

  assign imm_i_s = instr_in[31:20];
  assign imm_s_s = {instr_in[31:25], instr_in[11:7]};
  assign imm_b_s = {instr_in[31], instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0};
  assign imm_u_s = {instr_in[31:12], 12'b0};
  assign imm_j_s = {instr_in[31], instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0};

  entry_t          dec;
  logic [6:0]      opc, f7;
  logic [2:0]      f3, itype;
  logic [3:0]      alu;
  logic [ARCH-1:0] imm;
  logic            use_rs1, use_rs2, use_rd, use_f3, use_f7, bad;

  always_comb begin
    opc     = instr_in[6:0];
    f3      = instr_in[14:12];
    f7      = instr_in[31:25];
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    use_f3  = 1'b0;
    use_f7  = 1'b0;
    bad     = 1'b0;
    itype   = T_ILL;
    imm     = '0;
    alu     = ALU_ADD;
    case (opc)
      OP_R: begin
        itype = T_R; use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; use_f3 = 1'b1; use_f7 = 1'b1;
        alu = alu_from_f3(f3, f7[5], 1'b1);
        if (!(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)))) bad = 1'b1;
      end
      OP_IMM: begin
        itype = T_I; use_rs1 = 1'b1; use_rd = 1'b1; use_f3 = 1'b1;
        imm = ARCH'(imm_i_s);
        alu = alu_from_f3(f3, f7[5], 1'b0);
        // Only shift-immediates carry a func7; other OP-IMM ops use bit 30 as immediate.
        if (f3 == 3'b001 || f3 == 3'b101) begin
          use_f7 = 1'b1;
          if (!(f7 == 7'h00 || (f3 == 3'b101 && f7 == 7'h20))) bad = 1'b1;
        end
      end
      OP_LOAD, OP_JALR: begin
        itype = T_I; use_rs1 = 1'b1; use_rd = 1'b1; use_f3 = 1'b1;
        imm = ARCH'(imm_i_s);
        if (opc == OP_JALR && f3 != 3'b000) bad = 1'b1;
      end
      OP_STORE: begin
        itype = T_S; use_rs1 = 1'b1; use_rs2 = 1'b1; use_f3 = 1'b1;
        imm = ARCH'(imm_s_s);
      end
      OP_BRANCH: begin
        itype = T_B; use_rs1 = 1'b1; use_rs2 = 1'b1; use_f3 = 1'b1;
        imm = ARCH'(imm_b_s);
        alu = ALU_SUB;
      end
      OP_LUI, OP_AUIPC: begin
        itype = T_U; use_rd = 1'b1;
        imm = ARCH'(imm_u_s);
        alu = (opc == OP_LUI) ? ALU_PASS_B : ALU_ADD;
      end
      OP_JAL: begin
        itype = T_J; use_rd = 1'b1;
        imm = ARCH'(imm_j_s);
      end
      default: bad = 1'b1;
    endcase
    if (instr_in[1:0] != 2'b11) bad = 1'b1;
    if (REGFILE_DEPTH == 16 && ((use_rs1 && instr_in[19]) || (use_rs2 && instr_in[24]) ||
                                (use_rd && instr_in[11]))) bad = 1'b1;

    dec         = '0;
    dec.pc      = pc_in;
    dec.op_code = opc;
    if (bad) begin
      dec.itype   = T_ILL;
      dec.illegal = 1'b1;
    end else begin
      dec.itype = itype;
      dec.imm   = imm;
      dec.alu   = alu;
      dec.func3 = use_f3 ? f3 : 3'b000;
      dec.func7 = use_f7 ? f7 : 7'b0;
      dec.rs1   = use_rs1 ? instr_in[15 +: RW] : '0;
      dec.rs2   = use_rs2 ? instr_in[20 +: RW] : '0;
      dec.rd    = use_rd ? instr_in[7 +: RW] : '0;
    end
  end

  entry_t out_q, out_d;
  logic   valid_q, valid_d, load, accept;

`ifdef FRISCV_ID_SKID_EN
  entry_t skid_q, skid_d;
  logic   skid_valid_q, skid_valid_d;

  assign ready_out = !skid_valid_q;
`else
  assign ready_out = !valid_q | ready_in;
`endif

  assign accept = valid_in & ready_out;
  assign load   = !valid_q | ready_in;

  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
`ifdef FRISCV_ID_SKID_EN
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
`endif
    if (flush_in) begin
      valid_d = 1'b0;
`ifdef FRISCV_ID_SKID_EN
      skid_valid_d = 1'b0;
`endif
    end else if (load) begin
`ifdef FRISCV_ID_SKID_EN
      // A held skid entry is older than anything on the input, so it drains first.
      if (skid_valid_q) begin
        out_d        = skid_q;
        valid_d      = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        valid_d = accept;
        if (accept) out_d = dec;
      end
`else
      valid_d = accept;
      if (accept) out_d = dec;
`endif
    end
`ifdef FRISCV_ID_SKID_EN
    else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
`ifdef FRISCV_ID_SKID_EN
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
`endif
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
`ifdef FRISCV_ID_SKID_EN
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
`endif
    end
  end

  assign valid_out      = valid_q;
  assign pc_out         = out_q.pc;
  assign op_code_out    = out_q.op_code;
  assign func3_out      = out_q.func3;
  assign func7_out      = out_q.func7;
  assign rs1_out        = out_q.rs1;
  assign rs2_out        = out_q.rs2;
  assign rd_out         = out_q.rd;
  assign imm_out        = out_q.imm;
  assign instr_type_out = out_q.itype;
  assign alu_ctrl_out   = out_q.alu;
  assign illegal_out    = out_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: RV32 default, ARCH=64 and REGFILE_DEPTH=16 instances
// share one stimulus stream; expectations adapt to FRISCV_ID_SKID_EN.
module tb_instr_decode_stage;

`ifdef FRISCV_ID_SKID_EN
  localparam logic SKID = 1'b1;
`else
  localparam logic SKID = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b0;
  logic [31:0] instr_in = '0, pc_in = '0;
  logic        valid_in = 1'b0, flush_in = 1'b0, ready_in = 1'b0;

  logic        ready_out, valid_out, illegal_out;
  logic [31:0] pc_out, imm_out;
  logic [6:0]  op_code_out, func7_out;
  logic [2:0]  func3_out, instr_type_out;
  logic [4:0]  rs1_out, rs2_out, rd_out;
  logic [3:0]  alu_ctrl_out;

  logic        ready_64, valid_64, illegal_64;
  logic [63:0] pc_64, imm_64;
  logic [6:0]  op_64, f7_64;
  logic [2:0]  f3_64, type_64;
  logic [4:0]  rs1_64, rs2_64, rd_64;
  logic [3:0]  alu_64;

  logic        ready_e, valid_e, illegal_e;
  logic [31:0] pc_e, imm_e;
  logic [6:0]  op_e, f7_e;
  logic [2:0]  f3_e, type_e;
  logic [3:0]  rs1_e, rs2_e, rd_e;
  logic [3:0]  alu_e;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  instr_decode_stage dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .pc_in(pc_in), .valid_in(valid_in),
    .ready_out(ready_out), .flush_in(flush_in), .valid_out(valid_out), .ready_in(ready_in),
    .pc_out(pc_out), .op_code_out(op_code_out), .func3_out(func3_out), .func7_out(func7_out),
    .rs1_out(rs1_out), .rs2_out(rs2_out), .rd_out(rd_out), .imm_out(imm_out),
    .instr_type_out(instr_type_out), .alu_ctrl_out(alu_ctrl_out), .illegal_out(illegal_out));

  instr_decode_stage #(.ARCH(64)) dut64 (
    .clk(clk), .rst(rst), .instr_in(instr_in), .pc_in({32'h0, pc_in}), .valid_in(valid_in),
    .ready_out(ready_64), .flush_in(flush_in), .valid_out(valid_64), .ready_in(ready_in),
    .pc_out(pc_64), .op_code_out(op_64), .func3_out(f3_64), .func7_out(f7_64),
    .rs1_out(rs1_64), .rs2_out(rs2_64), .rd_out(rd_64), .imm_out(imm_64),
    .instr_type_out(type_64), .alu_ctrl_out(alu_64), .illegal_out(illegal_64));

  instr_decode_stage #(.REGFILE_DEPTH(16)) dute (
    .clk(clk), .rst(rst), .instr_in(instr_in), .pc_in(pc_in), .valid_in(valid_in),
    .ready_out(ready_e), .flush_in(flush_in), .valid_out(valid_e), .ready_in(ready_in),
    .pc_out(pc_e), .op_code_out(op_e), .func3_out(f3_e), .func7_out(f7_e),
    .rs1_out(rs1_e), .rs2_out(rs2_e), .rd_out(rd_e), .imm_out(imm_e),
    .instr_type_out(type_e), .alu_ctrl_out(alu_e), .illegal_out(illegal_e));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_entry(input string tag, input logic [31:0] pc, input logic [6:0] op,
                           input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] imm,
                           input logic [2:0] typ, input logic [3:0] alu, input logic ill);
    chk({tag, ".valid"}, valid_out, 1'b1);
    chk({tag, ".pc"}, pc_out, pc);
    chk({tag, ".op"}, op_code_out, op);
    chk({tag, ".f3"}, func3_out, f3);
    chk({tag, ".f7"}, func7_out, f7);
    chk({tag, ".rs1"}, rs1_out, rs1);
    chk({tag, ".rs2"}, rs2_out, rs2);
    chk({tag, ".rd"}, rd_out, rd);
    chk({tag, ".imm"}, imm_out, imm);
    chk({tag, ".type"}, instr_type_out, typ);
    chk({tag, ".alu"}, alu_ctrl_out, alu);
    chk({tag, ".ill"}, illegal_out, ill);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
    instr_in = ins;
    pc_in    = pc;
    valid_in = 1'b1;
  endtask

  initial begin
    #2 rst = 1'b1;
    tick();
    tick();
    chk("rst.valid", valid_out, 1'b0);
    chk("rst.pc", pc_out, 32'h0);
    chk("rst.imm", imm_out, 32'h0);
    chk("rst.rd", rd_out, 5'd0);
    chk("rst.ready", ready_out, 1'b1);
    chk("rst.valid64", valid_64, 1'b0);
    rst      = 1'b0;
    ready_in = 1'b1;

    // Back-to-back stream, one instruction per cycle.
    drive(32'hFFF00093, 32'h100); tick();
    exp_entry("addi", 32'h100, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'hFFFFFFFF, 3'd1, 4'd0, 1'b0);
    chk("addi.imm64", imm_64, 64'hFFFFFFFFFFFFFFFF);
    drive(32'h402081B3, 32'h104); tick();
    exp_entry("sub", 32'h104, 7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'h0, 3'd0, 4'd1, 1'b0);
    chk("sub.e_ill", illegal_e, 1'b0);
    chk("sub.e_rd", rd_e, 4'd3);
    drive(32'hFE000EE3, 32'h108); tick();
    exp_entry("beq", 32'h108, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 3'd3, 4'd1, 1'b0);
    drive(32'h123452B7, 32'h10C); tick();
    exp_entry("lui", 32'h10C, 7'h37, 3'd0, 7'h00, 5'd0, 5'd0, 5'd5, 32'h12345000, 3'd4, 4'd10, 1'b0);
    chk("lui.imm64", imm_64, 64'h0000000012345000);
    drive(32'h800002B7, 32'h110); tick();
    chk("luineg.imm", imm_out, 32'h80000000);
    chk("luineg.imm64", imm_64, 64'hFFFFFFFF80000000);
    chk("luineg.pc64", pc_64, 64'h110);
    drive(32'h00000000, 32'h114); tick();
    exp_entry("zero", 32'h114, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0, 3'd7, 4'd0, 1'b1);
    drive(32'h00208833, 32'h118); tick();
    exp_entry("add16", 32'h118, 7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd16, 32'h0, 3'd0, 4'd0, 1'b0);
    chk("add16.e_ill", illegal_e, 1'b1);
    chk("add16.e_type", type_e, 3'd7);
    chk("add16.e_rd", rd_e, 4'd0);
    chk("add16.e_pc", pc_e, 32'h118);
    drive(32'h4020C1B3, 32'h11C); tick();
    exp_entry("rbadf7", 32'h11C, 7'h33, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0, 3'd7, 4'd0, 1'b1);
    drive(32'h000010E7, 32'h120); tick();
    exp_entry("jalrf3", 32'h120, 7'h67, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0, 3'd7, 4'd0, 1'b1);
    drive(32'h40315093, 32'h124); tick();
    exp_entry("srai", 32'h124, 7'h13, 3'd5, 7'h20, 5'd2, 5'd0, 5'd1, 32'h403, 3'd1, 4'd7, 1'b0);
    drive(32'h0020A423, 32'h128); tick();
    exp_entry("sw", 32'h128, 7'h23, 3'd2, 7'h00, 5'd1, 5'd2, 5'd0, 32'h8, 3'd2, 4'd0, 1'b0);
    drive(32'hFF9FF06F, 32'h12C); tick();
    exp_entry("jal", 32'h12C, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFFFFF8, 3'd5, 4'd0, 1'b0);

    valid_in = 1'b0; tick();
    chk("drain.valid", valid_out, 1'b0);

    // Back-pressure: ready_in low for three edges.
    ready_in = 1'b0;
    drive(32'h00100093, 32'h200); tick();
    exp_entry("bpA1", 32'h200, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'h1, 3'd1, 4'd0, 1'b0);
    chk("bp1.ready", ready_out, SKID);
    drive(32'h00200113, 32'h204); tick();
    exp_entry("bpA2", 32'h200, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'h1, 3'd1, 4'd0, 1'b0);
    chk("bp2.ready", ready_out, 1'b0);
    tick();
    exp_entry("bpA3", 32'h200, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'h1, 3'd1, 4'd0, 1'b0);
    chk("bp3.ready", ready_out, 1'b0);
    ready_in = 1'b1; tick();
    exp_entry("bpB", 32'h204, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd2, 32'h2, 3'd1, 4'd0, 1'b0);
    chk("bpB.ready", ready_out, 1'b1);
    valid_in = 1'b0; tick();
    chk("bp.nodup", valid_out, 1'b0);

    // Flush under back-pressure drops held entries and the same-cycle input.
    ready_in = 1'b0;
    drive(32'h00300193, 32'h300); tick();
    chk("flC.pc", pc_out, 32'h300);
    drive(32'h00400213, 32'h304); tick();
    chk("flC.hold", pc_out, 32'h300);
    drive(32'h00500293, 32'h308);
    flush_in = 1'b1; tick();
    chk("flush.valid", valid_out, 1'b0);
    chk("flush.valid64", valid_64, 1'b0);
    flush_in = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b1; tick();
    chk("postfl.valid", valid_out, 1'b0);
    chk("postfl.ready", ready_out, 1'b1);

    // Asynchronous reset mid-stream.
    drive(32'h00600313, 32'h400); tick();
    chk("preRst.valid", valid_out, 1'b1);
    chk("preRst.rd", rd_out, 5'd6);
    #2 rst = 1'b1;
    #1;
    chk("midRst.valid", valid_out, 1'b0);
    chk("midRst.pc", pc_out, 32'h0);
    chk("midRst.rd", rd_out, 5'd0);
    chk("midRst.imm", imm_out, 32'h0);
    chk("midRst.op", op_code_out, 7'h0);
    chk("midRst.type", instr_type_out, 3'd0);
    valid_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("postRst.valid", valid_out, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
- Registered, parametrised instruction-decode pipeline stage with valid/ready handshakes on both sides.
- Sits between the fetch and execute stages.
- Splits 32-bit RV32I/E instructions into fields, builds the sign-extended immediate at ARCH width, generates ALU control, and flags illegal encodings.
- Adds flush and back-pressure handling that a purely combinational decoder lacks.

Parameters:
- ARCH, 32, datapath width (32 or 64); immediate and PC width.
- REGFILE_DEPTH, 32, register count (32 = RV32I, 16 = RV32E); index width RW = $clog2(REGFILE_DEPTH).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- instr_in  in  32  instruction from fetch
- pc_in  in  ARCH  PC of instr_in
- valid_in  in  1  instr_in/pc_in valid
- ready_out  out  1  stage can accept (to fetch)
- flush_in  in  1  discard all held entries (branch redirect)
- valid_out  out  1  decoded entry valid
- ready_in  in  1  execute accepts entry
- pc_out  out  ARCH  PC of decoded entry
- op_code_out  out  7  instr[6:0]
- func3_out  out  3  instr[14:12], or 0 if unused by type
- func7_out  out  7  instr[31:25] for R-type and shift-imm, else 0
- rs1_out / rs2_out / rd_out  out  RW each  register indices, 0 if unused by type
- imm_out  out  ARCH  sign-extended immediate
- instr_type_out  out  3  0=R 1=I 2=S 3=B 4=U 5=J 7=illegal
- alu_ctrl_out  out  4  ALU operation code
- illegal_out  out  1  illegal instruction flag

Behaviour:
- Reset (async assert, sync release): valid_out=0; every data output 0; any skid entry empty.
- Accept on valid_in & ready_out; decoded entry appears on outputs next cycle (latency 1). Transfer out on valid_out & ready_in.
- Output register loads when empty or when ready_in=1. Outputs hold stable while valid_out=1 and ready_in=0.
- Opcodes:
  - 0110011 R
  - 0010011, 0000011, 1100111 I
  - 0100011 S
  - 1100011 B
  - 0110111, 0010111 U
  - 1101111 J
- rd=instr[11:7]; rs1=instr[19:15]; rs2=instr[24:20].
- Immediates, sign-extended to ARCH:
  - I: instr[31:20]
  - S: {instr[31:25],instr[11:7]}
  - B: {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}
  - U: {instr[31:12],12'b0}
  - J: {instr[31],instr[19:12],instr[20],instr[30:21],1'b0}
- alu_ctrl codes: ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9 PASS_B=10.
  - R and OP-IMM: decoded from func3/func7[5]; SUB only for R.
  - Loads, stores, JALR, AUIPC, JAL: ADD.
  - Branch: SUB.
  - LUI: PASS_B.
- Illegal when any of:
  - instr[1:0]!=11
  - unknown opcode
  - R-type func7 not in {0x00,0x20}, or 0x20 with func3 not in {000,101}
  - shift-imm func7 not 0x00 (or 0x20 for SRAI)
  - JALR func3!=0
  - REGFILE_DEPTH=16 and bit 4 set in any used register field
- Illegal entries: still passed with valid_out=1; illegal_out=1, type=7; all other fields 0 except pc_out and op_code_out.
- flush_in=1: valid_out=0 next cycle, skid emptied, and any same-cycle input is dropped. Flush has priority over accept and over hold.

Optional Feature:
- Macro FRISCV_ID_SKID_EN.
- Defined:
  - Adds a one-entry skid buffer; ready_out = !skid_valid, driven from a flop, with no combinational path from ready_in.
  - With full occupancy the stage holds 2 entries; full throughput is sustained.
- Undefined:
  - No skid; ready_out = !valid_out | ready_in (combinational).
  - Single entry.
- Ordering and per-entry data are identical in both builds.

Test Plan:
- 0xFFF00093 (addi x1,x0,-1), ready_in=1 -> next cycle valid_out=1, rd=1, rs1=0, imm=0xFFFFFFFF, type=1, alu=ADD, illegal=0.
- 0x402081B3 (sub x3,x1,x2) -> rd=3, rs1=1, rs2=2, func7=0x20, alu=SUB; 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC, type=3, rd=0.
- 0x123452B7 (lui x5,0x12345) -> imm=0x12345000, alu=PASS_B; with ARCH=64, 0x800002B7 -> imm=0xFFFFFFFF80000000.
- Back-to-back stream with ready_in low 3 cycles:
  - Outputs stable throughout; no drop or duplicate.
  - ready_out falls after 1 entry (no skid) or 2 entries (FRISCV_ID_SKID_EN).
- 0x00000000 -> illegal=1, type=7; REGFILE_DEPTH=16 with add x16,x1,x2 (0x00208833) -> illegal=1.
- Under back-pressure, assert flush_in with valid_in=1 -> valid_out=0 next cycle and input dropped; rst mid-stream -> all outputs 0 immediately.
